// File: rtl/ms_es_byn_mul.sv
// ms_es_byn_mul: clock-division stochastic multiplier, LANES bits per cycle.
// Define MS_ES_EARLY_STOP_EN to stop after the last block that can add ones.
module ms_es_byn_mul #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_INPUTS = 2,
  parameter int LANES      = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [DATA_WIDTH-1:0]            bin_data_in [NUM_INPUTS-1:0],
  output logic [DATA_WIDTH*NUM_INPUTS-1:0] bin_data_out,
  output logic                             done,
  output logic                             busy
);
  localparam int OUT_WIDTH = DATA_WIDTH * NUM_INPUTS;
  localparam int CW        = DATA_WIDTH + 1;

  localparam logic [CW-1:0]        L_C = CW'(LANES);
  localparam logic [OUT_WIDTH-1:0] L_T = OUT_WIDTH'(LANES);
  localparam logic [OUT_WIDTH-1:0] L_M = OUT_WIDTH'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] x_q [NUM_INPUTS-1:0];
  logic [OUT_WIDTH-1:0]  t_q;
  logic [OUT_WIDTH-1:0]  acc_q;
  logic [OUT_WIDTH-1:0]  sum;
  logic [DATA_WIDTH-1:0] d0;
  logic [CW-1:0]         diff;
  logic [CW-1:0]         cnt;
  logic                  gate;
  logic                  last;

  // Ones in the current block: upper digits gate, d_0 spans LANES values
  always_comb begin
    gate = 1'b1;
    for (int i = 1; i < NUM_INPUTS; i++) begin
      if (t_q[DATA_WIDTH*i +: DATA_WIDTH] >= x_q[i]) gate = 1'b0;
    end
    d0   = t_q[DATA_WIDTH-1:0];
    diff = {1'b0, x_q[0]} - {1'b0, d0};
    cnt  = '0;
    if (gate && (x_q[0] > d0)) begin
      cnt = (diff > L_C) ? L_C : diff;
    end
    sum = acc_q + OUT_WIDTH'(cnt);
  end

`ifdef MS_ES_EARLY_STOP_EN
  localparam int LO = DATA_WIDTH * (NUM_INPUTS - 1);

  logic any_zero;
  logic low_ones;

  // Stop at the last block with d_(K-1) = x_(K-1)-1, or at once on a zero
  always_comb begin
    any_zero = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (x_q[i] == '0) any_zero = 1'b1;
    end
    low_ones = &(t_q[LO-1:0] | L_M[LO-1:0]);
    last = any_zero ||
           (low_ones &&
            (t_q[LO +: DATA_WIDTH] ==
             x_q[NUM_INPUTS-1] - DATA_WIDTH'(1)));
  end
`else
  // Final block: every bit above the lane offset is one, so t wraps next
  always_comb begin
    last = &(t_q | L_M);
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; en in DONE is ignored
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (en) state_nx = RUN;
      RUN:     if (en && last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, stream time, accumulator and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_INPUTS; i++) x_q[i] <= '0;
      t_q          <= '0;
      acc_q        <= '0;
      bin_data_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (en) begin
            x_q   <= bin_data_in;
            t_q   <= '0;
            acc_q <= '0;
          end
        end
        RUN: begin
          if (en) begin
            t_q   <= t_q + L_T;
            acc_q <= sum;
            if (last) bin_data_out <= sum;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_ms_es_byn_mul.sv
// tb_ms_es_byn_mul: scoreboard bench for the stochastic multiplier.
// Random operands, pauses and input changes against a stream-count model.
module tb_ms_es_byn_mul;
  localparam int W = 4;
  localparam int K = 2;
  localparam int L = 4;
  localparam int OW = W * K;

  typedef struct {
    longint res;
    int     cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [W-1:0]  xin [K-1:0];
  logic [OW-1:0] bin_data_out;
  logic          done;
  logic          busy;

  int     n_tests = 0;
  int     n_fail  = 0;
  exp_t   sb [$];
  int     bc      = 0;
  longint held    = 0;
  exp_t   me;

  ms_es_byn_mul #(
    .DATA_WIDTH(W),
    .NUM_INPUTS(K),
    .LANES     (L)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .bin_data_in (xin),
    .bin_data_out(bin_data_out),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint got,
                       input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Count ones of the full product stream straight from its definition
  function automatic longint ref_count(input int a, input int b);
    longint s = 0;
    for (int t = 0; t < (1 << OW); t++) begin
      if ((t % (1 << W)) < a && (t / (1 << W)) < b) s++;
    end
    return s;
  endfunction

  function automatic int exp_edges(input int a, input int b);
`ifdef MS_ES_EARLY_STOP_EN
    if (a == 0 || b == 0) return 1;
    return b * (1 << W) / L;
`else
    if (a < 0 || b < 0) return 0;
    return (1 << OW) / L;
`endif
  endfunction

  task automatic run_op(input int a, input int b,
                        input int pa_in, input int pl_in);
    int   n;
    int   pa;
    int   pl;
    bit   seen;
    exp_t e;
    n  = exp_edges(a, b);
    pa = pa_in;
    pl = pl_in;
    if (pa < 0 || pa >= n) begin
      pa = -1;
      pl = 0;
    end
    @(negedge clk);
    xin[0] = W'(a);
    xin[1] = W'(b);
    en     = 1'b1;
    e.res  = ref_count(a, b);
    e.cyc  = n + pl;
    sb.push_back(e);
    @(posedge clk);
    seen = 1'b0;
    for (int c = 0; c < n + pl + 5 && !seen; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        xin[0] = W'($urandom);
        xin[1] = W'($urandom);
        if (c == pa) en = 1'b0;
        if (c == pa + pl) en = 1'b1;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout a=%0d b=%0d got=no_done exp=done", a, b);
      rst = 1'b1;
      en  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      return;
    end
    @(posedge clk);
    #1;
    check("done_one_cycle", longint'(done), 0);
    check("en_ignored_in_done", longint'(busy), 0);
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic reset_mid();
    int nd;
    @(negedge clk);
    xin[0] = W'(9);
    xin[1] = W'(9);
    en     = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 20; c++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_out", longint'(bin_data_out), 0);
    check("rst_mid_busy", longint'(busy), 0);
    check("rst_mid_done", longint'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    nd  = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    check("no_done_after_rst", longint'(nd), 0);
  endtask

  // Monitor: pops the scoreboard on done, checks output stability in RUN
  initial begin
    forever begin
      @(negedge clk);
      check("busy_done_excl", longint'(busy & done), 0);
      if (busy) begin
        bc++;
        check("out_stable_run", longint'(bin_data_out), held);
      end else if (done) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done got=done exp=none");
        end else begin
          me = sb.pop_front();
          check("result", longint'(bin_data_out), me.res);
          check("busy_cycles", longint'(bc), longint'(me.cyc));
        end
        bc   = 0;
        held = longint'(bin_data_out);
      end else begin
        bc   = 0;
        held = longint'(bin_data_out);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < K; i++) xin[i] = W'(i + 3);
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", longint'(bin_data_out), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_done", longint'(done), 0);
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;
    run_op(5, 3, -1, 0);
    run_op(15, 15, -1, 0);
    run_op(0, 9, -1, 0);
    run_op(15, 0, -1, 0);
    run_op(7, 2, 3, 10);
    reset_mid();
    run_op(2, 2, -1, 0);
    run_op(1, 1, 0, 2);
    run_op(15, 1, -1, 0);
    for (int r = 0; r < 20; r++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 70)), int'($urandom_range(0, 5)));
    end
    repeat (5) @(negedge clk);
    check("sb_empty", longint'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
